mdu_divider: RTL
================

Name: mdu_divider

Overview:
Multi-cycle iterative integer divider for the execute stage's mult/div unit. It feeds the first-pipeline ALU, which launches a DIV/DIVU by driving a non-zero op while `done` is high, stalls while `done` is low, and commits `result` into HI/LO on the rising edge of `done`. Radix-2 restoring algorithm on magnitudes with a final sign fix-up; one quotient bit per cycle.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= DATA_W.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- div_op  in  2  launch/type: 2'b10 = signed DIV, 2'b01 = unsigned DIVU, 2'b00 or 2'b11 = no operation.
- dividend  in  DATA_W  rs operand; sampled only on the launch edge.
- divisor  in  DATA_W  rt operand; sampled only on the launch edge.
- result  out  2*DATA_W  {remainder, quotient}, i.e. {HI, LO}; held stable between completions.
- done  out  1  high = idle, and `result` is valid for the last completed op.

Behaviour:
- Reset, asynchronous, effective at any time including mid-operation:
  - state = IDLE, done = 1, result = 0, counter = 0.
  - An operation in flight is discarded; nothing completes for it.
- State machine:
  - IDLE -> CALC on a rising edge with state == IDLE and div_op in {10, 01}. That edge (e0) does all of the following:
    - latches the operand magnitudes; for signed ops negative operands are two's-complement negated, for unsigned ops operands pass through;
    - latches q_neg = dividend[MSB] ^ divisor[MSB] (signed only) and r_neg = dividend[MSB] (signed only);
    - latches a div_by_zero flag (divisor == 0);
    - clears the DATA_W+1-bit partial remainder and sets counter = 0;
    - drives done to 0.
  - CALC, once per edge:
    - trial = {partial_rem[DATA_W-1:0], dvd_shift[MSB]} - {1'b0, |divisor|};
    - if trial is non-negative, partial_rem = trial and quotient bit = 1; otherwise partial_rem is the shifted value and quotient bit = 0;
    - the quotient shifts in from the LSB; counter increments;
    - the edge where counter == DATA_W-1 moves to FIX.
  - FIX -> IDLE on one edge (e33 for DATA_W = 32), which writes `result` and sets done = 1:
    - signed: quotient = q_neg ? -q : q; remainder = r_neg ? -r : r;
    - div_by_zero overrides: quotient = {DATA_W{1'b1}}, remainder = the original dividend, for both signed and unsigned.
- Latency: done is low for exactly DATA_W+1 cycles (33). `result` is valid on the same edge done rises.
- div_op is ignored in CALC and FIX; operand changes during CALC and FIX have no effect.
- A non-zero div_op held in IDLE after completion re-launches. The ALU's done-edge gating prevents this, and the divider does not filter it.
- `result` keeps its previous value throughout CALC and is updated only in FIX.
- Edge cases:
  - 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0, no trap.
  - Dividend 0: quotient 0, remainder 0.
  - |dividend| < |divisor|: quotient 0, remainder = dividend with its sign.
- There are no X outputs: the state register has a default branch that returns to IDLE with done = 1.

Decomposition:
- Add to define.v:
  - DIV_OP_SIGNED = 2'b10 and DIV_OP_UNSIGNED = 2'b01, shared with the multiplier op encoding;
  - state encodings DIV_IDLE, DIV_CALC, DIV_FIX.
- No sub-module. The datapath (abs/negate, trial subtract, shift registers) and the FSM live in one file; the negate is a local function.

Test Plan:
- Unsigned: div_op = 01, dividend = 100, divisor = 7. done falls on the next edge and rises 33 cycles later with result = {32'd2, 32'd14}.
- Signed: div_op = 10, dividend = 0xFFFFFFF9 (-7), divisor = 2. Expect result = {0xFFFFFFFF, 0xFFFFFFFD}. Then 7 / -2 gives {0x00000001, 0xFFFFFFFD}.
- Overflow corner: signed 0x80000000 / 0xFFFFFFFF gives {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF / 1 gives {0, 0xFFFFFFFF}.
- Divide by zero: unsigned 0x1234 / 0 and signed 0xFFFFFF00 / 0 give {dividend, 0xFFFFFFFF}, with full 33-cycle latency.
- Busy and hold:
  - launch 50 / 5, then drive div_op = 10 with new operands at cycles 5 and 20: result is still {0, 10} at completion;
  - result is unchanged from its prior value during CALC;
  - 2'b11 in IDLE does not launch.
- Async reset: assert resetn = 0 mid-way, at cycle 15 of CALC and between clock edges. done = 1 and result = 0 immediately with no clock. After release, a new 9 / 3 returns {0, 3}.

Source files
------------

// File: rtl/mdu_divider_pkg.sv
// Shared encodings for the mult/div unit.
// Op codes are common to the multiplier and divider.
package mdu_divider_pkg;

  localparam logic [1:0] DIV_OP_SIGNED   = 2'b10;
  localparam logic [1:0] DIV_OP_UNSIGNED = 2'b01;

  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_CALC = 2'b01;
  localparam logic [1:0] DIV_FIX  = 2'b10;

endpackage

// File: rtl/mdu_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle.
// Magnitudes are divided, signs are fixed up in a final cycle.
module mdu_divider
  import mdu_divider_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            div_op,
  input  logic [DATA_W-1:0]     dividend,
  input  logic [DATA_W-1:0]     divisor,
  output logic [2*DATA_W-1:0]   result,
  output logic                  done
);

  function automatic logic [DATA_W-1:0] neg(
    input logic [DATA_W-1:0] v
  );
    return {DATA_W{1'b0}} - v;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dsr_q, dsr_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   orig_q, orig_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic                dbz_q, dbz_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                done_q, done_d;

  logic                sgn;
  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   q_fix;
  logic [DATA_W-1:0]   r_fix;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    orig_d   = orig_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dbz_d    = dbz_q;
    result_d = result_q;
    done_d   = done_q;
    sgn      = (div_op == DIV_OP_SIGNED);
    shifted  = {rem_q, dvd_q[DATA_W-1]};
    trial    = shifted - {1'b0, dsr_q};
    q_fix    = q_neg_q ? neg(quo_q) : quo_q;
    r_fix    = r_neg_q ? neg(rem_q) : rem_q;

    case (state_q)
      DIV_IDLE: begin
        if (div_op == DIV_OP_SIGNED ||
            div_op == DIV_OP_UNSIGNED) begin
          dvd_d   = (sgn && dividend[DATA_W-1])
                    ? neg(dividend) : dividend;
          dsr_d   = (sgn && divisor[DATA_W-1])
                    ? neg(divisor) : divisor;
          q_neg_d = sgn &
                    (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
          r_neg_d = sgn & dividend[DATA_W-1];
          dbz_d   = (divisor == '0);
          orig_d  = dividend;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = DIV_CALC;
        end
      end
      DIV_CALC: begin
        // trial[MSB] set means the subtract borrowed
        if (!trial[DATA_W]) begin
          rem_d = trial[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = shifted[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
        dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W-1))
          state_d = DIV_FIX;
      end
      DIV_FIX: begin
        if (dbz_q)
          result_d = {orig_q, {DATA_W{1'b1}}};
        else
          result_d = {r_fix, q_fix};
        done_d  = 1'b1;
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      orig_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      orig_q   <= orig_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dbz_q    <= dbz_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule
